alu_muldiv: RTL and testbench

Parametrised-width execute-stage ALU: the next generation of the single-cycle integer ALU. It adds RV32M multiply/divide, signed-correct shifts, a full flag set (carry, zero, overflow, negative) and a valid/ready handshake. Single-cycle operations retire at one per clock. Multiply and divide run on an iterative shift-add / restoring datapath, and the block back-pressures the pipeline through `in_ready` while they run.

---
 rtl/alu_muldiv.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Execute-stage integer ALU with single-cycle ops plus iterative RV32M multiply/divide.
// Single-cycle results retire immediately; mul/div hold off new work via in_ready until FIN.
module alu_muldiv #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op_val,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  output logic [XLEN-1:0] result_out,
  output logic [XLEN-1:0] result_comb,
  output logic            carry_flag,
  output logic            zero_flag,
  output logic            overflow_flag,
  output logic            negative_flag
);

  localparam logic [4:0] OP_ADD    = 5'h01;
  localparam logic [4:0] OP_SUB    = 5'h02;
  localparam logic [4:0] OP_SLT    = 5'h03;
  localparam logic [4:0] OP_AND    = 5'h04;
  localparam logic [4:0] OP_OR     = 5'h05;
  localparam logic [4:0] OP_XOR    = 5'h06;
  localparam logic [4:0] OP_SLL    = 5'h07;
  localparam logic [4:0] OP_SRL    = 5'h08;
  localparam logic [4:0] OP_SRA    = 5'h09;
  localparam logic [4:0] OP_SLTU   = 5'h0B;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  localparam int MSB = XLEN - 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t          r_state;
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opd;
  logic [2:0]      r_sel;
  logic            r_neg0;
  logic            r_neg1;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_carry;
  logic            r_zero;
  logic            r_ovf;
  logic            r_neg;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_dif;
  logic [SHW-1:0]  w_shamt;
  logic            w_b_zero;
  logic            w_div_ovf;
  logic [XLEN-1:0] w_comb_res;
  logic            w_comb_c;
  logic            w_comb_v;
  logic            w_comb_known;
  logic            w_is_muldiv;
  logic            w_accept;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN:0]   w_add;
  logic [XLEN:0]   w_rsh;
  logic [XLEN:0]   w_rsub;
  logic [2*XLEN-1:0] w_prod_raw;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_fin_res;

  assign w_sum     = {1'b0, operand_a} + {1'b0, operand_b};
  assign w_dif     = {1'b0, operand_a} - {1'b0, operand_b};
  assign w_shamt   = operand_b[SHW-1:0];
  assign w_b_zero  = (operand_b == '0);
  assign w_div_ovf = (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);

  // Division special cases resolve here so the iterative path only sees well-defined divides.
  always_comb begin
    w_comb_res   = '0;
    w_comb_c     = 1'b0;
    w_comb_v     = 1'b0;
    w_comb_known = 1'b1;
    w_is_muldiv  = 1'b0;
    case (op_val)
      OP_ADD: begin
        w_comb_res = w_sum[MSB:0];
        w_comb_c   = w_sum[XLEN];
        w_comb_v   = (operand_a[MSB] == operand_b[MSB]) && (w_sum[MSB] != operand_a[MSB]);
      end
      OP_SUB: begin
        w_comb_res = w_dif[MSB:0];
        w_comb_c   = w_dif[XLEN];
        w_comb_v   = (operand_a[MSB] != operand_b[MSB]) && (w_dif[MSB] != operand_a[MSB]);
      end
      OP_SLT:  w_comb_res = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: w_comb_res = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
      OP_AND:  w_comb_res = operand_a & operand_b;
      OP_OR:   w_comb_res = operand_a | operand_b;
      OP_XOR:  w_comb_res = operand_a ^ operand_b;
      OP_SLL:  w_comb_res = operand_a << w_shamt;
      OP_SRL:  w_comb_res = operand_a >> w_shamt;
      OP_SRA:  w_comb_res = $unsigned($signed(operand_a) >>> w_shamt);
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: w_is_muldiv = 1'b1;
      OP_DIV: begin
        if (w_b_zero)       w_comb_res = '1;
        else if (w_div_ovf) w_comb_res = operand_a;
        else                w_is_muldiv = 1'b1;
      end
      OP_DIVU: begin
        if (w_b_zero) w_comb_res = '1;
        else          w_is_muldiv = 1'b1;
      end
      OP_REM: begin
        if (w_b_zero)       w_comb_res = operand_a;
        else if (w_div_ovf) w_comb_res = '0;
        else                w_is_muldiv = 1'b1;
      end
      OP_REMU: begin
        if (w_b_zero) w_comb_res = operand_a;
        else          w_is_muldiv = 1'b1;
      end
      default: w_comb_known = 1'b0;
    endcase
  end

  assign result_comb = w_comb_res;
  assign in_ready    = (r_state == S_IDLE) && !halt;
  assign w_accept    = in_valid && in_ready && !flush;

  // Signedness per op: a is signed for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM.
  assign w_a_neg = operand_a[MSB] &&
                   ((op_val == OP_MULH) || (op_val == OP_MULHSU) || (op_val == OP_DIV) || (op_val == OP_REM));
  assign w_b_neg = operand_b[MSB] &&
                   ((op_val == OP_MULH) || (op_val == OP_DIV) || (op_val == OP_REM));
  assign w_a_mag = w_a_neg ? (~operand_a + 1'b1) : operand_a;
  assign w_b_mag = w_b_neg ? (~operand_b + 1'b1) : operand_b;

  assign w_add  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : {(XLEN+1){1'b0}});
  assign w_rsh  = {r_hi, r_lo[MSB]};
  assign w_rsub = w_rsh - {1'b0, r_opd};

  assign w_prod_raw = {r_hi, r_lo};
  assign w_prod     = r_neg0 ? (~w_prod_raw + 1'b1) : w_prod_raw;
  assign w_quo      = r_neg0 ? (~r_lo + 1'b1) : r_lo;
  assign w_rem      = r_neg1 ? (~r_hi + 1'b1) : r_hi;

  always_comb begin
    w_fin_res = '0;
    case (r_sel)
      3'd0:             w_fin_res = w_prod[MSB:0];
      3'd1, 3'd2, 3'd3: w_fin_res = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_fin_res = w_quo;
      default:          w_fin_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opd       <= '0;
      r_sel       <= '0;
      r_neg0      <= 1'b0;
      r_neg1      <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_neg       <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else if (!halt) begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_muldiv) begin
              // Multiply: r_opd = multiplicand, r_lo = multiplier. Divide: r_opd = divisor, r_lo = dividend.
              r_sel  <= op_val[2:0];
              r_cnt  <= '0;
              r_hi   <= '0;
              r_lo   <= op_val[2] ? w_a_mag : w_b_mag;
              r_opd  <= op_val[2] ? w_b_mag : w_a_mag;
              r_neg0 <= w_a_neg ^ w_b_neg;
              r_neg1 <= w_a_neg;
              r_state <= op_val[2] ? S_DIV : S_MUL;
            end else begin
              r_result    <= w_comb_res;
              r_carry     <= w_comb_c;
              r_ovf       <= w_comb_v;
              r_zero      <= w_comb_known && (w_comb_res == '0);
              r_neg       <= w_comb_res[MSB];
              r_out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          {r_hi, r_lo} <= {w_add, r_lo[MSB:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == SHW'(XLEN - 1)) r_state <= S_FIN;
        end
        S_DIV: begin
          r_hi  <= w_rsub[XLEN] ? w_rsh[MSB:0] : w_rsub[MSB:0];
          r_lo  <= {r_lo[MSB-1:0], ~w_rsub[XLEN]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == SHW'(XLEN - 1)) r_state <= S_FIN;
        end
        default: begin
          r_result    <= w_fin_res;
          r_carry     <= 1'b0;
          r_ovf       <= 1'b0;
          r_zero      <= (w_fin_res == '0);
          r_neg       <= w_fin_res[MSB];
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid     = r_out_valid;
  assign result_out    = r_result;
  assign carry_flag    = r_carry;
  assign zero_flag     = r_zero;
  assign overflow_flag = r_ovf;
  assign negative_flag = r_neg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed corner cases plus random ops against a plain-arithmetic model.
module tb_alu_muldiv;
  localparam int XLEN = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n, halt, flush, in_valid, in_ready, out_valid;
  logic [4:0] op_val;
  logic [XLEN-1:0] operand_a, operand_b, result_out, result_comb;
  logic carry_flag, zero_flag, overflow_flag, negative_flag;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op_val(op_val),
    .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid),
    .result_out(result_out), .result_comb(result_comb),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .overflow_flag(overflow_flag), .negative_flag(negative_flag)
  );

  // Returns {carry, zero, overflow, negative, result}.
  function automatic logic [35:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic c, v, known;
    longint sa, sb, t;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0; known = 1'b1;
    case (op)
      5'h01: begin r = a + b; t = sa + sb; c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF; v = (t > MAXS) || (t < MINS); end
      5'h02: begin r = a - b; t = sa - sb; c = (a < b); v = (t > MAXS) || (t < MINS); end
      5'h03: r = (sa < sb) ? 32'd1 : 32'd0;
      5'h0B: r = (a < b) ? 32'd1 : 32'd0;
      5'h04: r = a & b;
      5'h05: r = a | b;
      5'h06: r = a ^ b;
      5'h07: r = a << b[4:0];
      5'h08: r = a >> b[4:0];
      5'h09: r = 32'($signed(a) >>> b[4:0]);
      5'h10: begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
      5'h11: begin up = 64'(sa * sb); r = up[63:32]; end
      5'h12: begin up = 64'(sa * longint'({32'b0, b})); r = up[63:32]; end
      5'h13: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      5'h14: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = 32'(sa / sb);
      end
      5'h15: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'h16: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else r = 32'(sa % sb);
      end
      5'h17: r = (b == 0) ? a : a % b;
      default: known = 1'b0;
    endcase
    return {c, known && (r == 0), v, r[31], r};
  endfunction

  // Edges after the accept edge until out_valid: 0 for single-cycle, XLEN+1 for iterative.
  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 5'h10 || op > 5'h17) return 0;
    if (op >= 5'h14 && b == 0) return 0;
    if ((op == 5'h14 || op == 5'h16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return XLEN + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int ir_low, output logic [35:0] got);
    in_valid = 1'b1; op_val = op; operand_a = a; operand_b = b;
    step();
    in_valid = 1'b0;
    lat = 0; ir_low = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) ir_low++;
      step();
      lat++;
    end
    got = {carry_flag, zero_flag, overflow_flag, negative_flag, result_out};
    $display("txn op=%h a=%h b=%h res=%h flags=%b lat=%0d", op, a, b, result_out, got[35:32], lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; halt = 1'b0; flush = 1'b0; in_valid = 1'b0;
    op_val = '0; operand_a = '0; operand_b = '0;
    #12;
    total++;
    if ({out_valid, result_out, carry_flag, zero_flag, overflow_flag, negative_flag} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {out_valid, result_out, carry_flag, zero_flag, overflow_flag, negative_flag});
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    halt = 1'b1; #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL halt_in_ready got=%b want=0", in_ready); end
    halt = 1'b0;
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    int lat, irl;
    logic [35:0] got;
    run_op(5'h01, 32'hFFFF_FFFF, 32'h1, lat, irl, got);
    total++;
    if (got !== {4'b1100, 32'h0} || lat !== 0) begin bad++; $display("FAIL add_carry got=%h lat=%0d want=%h lat=0", got, lat, {4'b1100, 32'h0}); end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL add_pulse_width got=%b want=0", out_valid); end
    run_op(5'h01, 32'h7FFF_FFFF, 32'h1, lat, irl, got);
    total++;
    if (got !== {4'b0011, 32'h8000_0000}) begin bad++; $display("FAIL add_overflow got=%h want=%h", got, {4'b0011, 32'h8000_0000}); end
  endtask

  task automatic test_shift_cmp();
    logic [4:0] ops [4] = '{5'h09, 5'h08, 5'h0B, 5'h03};
    logic [31:0] as [4] = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1};
    logic [31:0] bs [4] = '{32'h24, 32'h24, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] want [4] = '{32'hF800_0000, 32'h0800_0000, 32'h1, 32'h0};
    int lat, irl;
    logic [35:0] got;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, irl, got);
      total++;
      if (got[31:0] !== want[i]) begin bad++; $display("FAIL shift_cmp_%0d got=%h want=%h", i, got[31:0], want[i]); end
    end
  endtask

  task automatic test_mul();
    logic [4:0] ops [3] = '{5'h10, 5'h13, 5'h11};
    logic [31:0] want [3] = '{32'h1, 32'hFFFF_FFFE, 32'h0};
    int lat, irl;
    logic [35:0] got;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, irl, got);
      total++;
      if (got[31:0] !== want[i]) begin bad++; $display("FAIL mul_%0d got=%h want=%h", i, got[31:0], want[i]); end
      total++;
      if (lat !== 33 || irl !== 33) begin bad++; $display("FAIL mul_latency_%0d got=%0d/%0d want=33/33", i, lat, irl); end
    end
  endtask

  task automatic test_div();
    logic [4:0] ops [5] = '{5'h14, 5'h16, 5'h15, 5'h17, 5'h14};
    logic [31:0] as [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000};
    logic [31:0] bs [5] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] want [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
    int wlat [5] = '{33, 33, 0, 0, 0};
    int lat, irl;
    logic [35:0] got;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], lat, irl, got);
      total++;
      if (got[31:0] !== want[i] || lat !== wlat[i]) begin
        bad++; $display("FAIL div_%0d got=%h lat=%0d want=%h lat=%0d", i, got[31:0], lat, want[i], wlat[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic [31:0] a, b;
    logic [35:0] exp;
    int lat;
    a = $urandom; b = {1'b0, 31'($urandom)} | 32'h1;
    exp = ref_model(5'h14, a, b);
    in_valid = 1'b1; op_val = 5'h14; operand_a = a; operand_b = b;
    step();
    in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 100) begin
      halt = (lat >= 10 && lat < 15);
      step();
      lat++;
    end
    halt = 1'b0;
    $display("txn halted DIV a=%h b=%h res=%h lat=%0d", a, b, result_out, lat);
    total++;
    if (lat !== 38 || {carry_flag, zero_flag, overflow_flag, negative_flag, result_out} !== exp) begin
      bad++; $display("FAIL halt_div got=%h lat=%0d want=%h lat=38", result_out, lat, exp[31:0]);
    end
    in_valid = 1'b1; op_val = 5'h05; operand_a = 32'h0F; operand_b = 32'hF0;
    step();
    in_valid = 1'b0; halt = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL halt_hold_valid got=%b%b want=10", out_valid, in_ready); end
    halt = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0 || result_out !== 32'hFF) begin bad++; $display("FAIL halt_release got=%b/%h want=0/000000ff", out_valid, result_out); end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int lat, irl, seen;
    logic [35:0] got;
    prev = result_out;
    in_valid = 1'b1; op_val = 5'h01; operand_a = 32'h5; operand_b = 32'h6; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    total++;
    if (out_valid !== 1'b0 || result_out !== prev) begin bad++; $display("FAIL flush_no_accept got=%b/%h want=0/%h", out_valid, result_out, prev); end
    in_valid = 1'b1; op_val = 5'h10; operand_a = 32'h1234_5678; operand_b = 32'h9;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result_out !== prev) begin
      bad++; $display("FAIL flush_mul got=%b%b/%h want=01/%h", out_valid, in_ready, result_out, prev);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin step(); if (out_valid) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL flush_stray_valid got=%0d want=0", seen); end
    run_op(5'h01, 32'd100, 32'd23, lat, irl, got);
    total++;
    if (got !== ref_model(5'h01, 32'd100, 32'd23) || lat !== 0) begin bad++; $display("FAIL flush_then_add got=%h want=%h", got, ref_model(5'h01, 32'd100, 32'd23)); end
  endtask

  task automatic test_reset_mid();
    int seen;
    in_valid = 1'b1; op_val = 5'h14; operand_a = 32'h7654_3210; operand_b = 32'h33;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, result_out, carry_flag, zero_flag, overflow_flag, negative_flag} !== '0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid got=%b/%h/%b want=0/0/1", out_valid, result_out, in_ready);
    end
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin step(); if (out_valid) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL reset_mid_stray got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] singles [11] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0B, 5'h1E};
    logic [35:0] exp;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op_val = singles[$urandom_range(0, 10)];
      operand_a = $urandom; operand_b = $urandom;
      exp = ref_model(op_val, operand_a, operand_b);
      #1;
      total++;
      if (result_comb !== exp[31:0]) begin bad++; $display("FAIL b2b_comb_%0d got=%h want=%h", i, result_comb, exp[31:0]); end
      step();
      $display("txn b2b op=%h a=%h b=%h res=%h", op_val, operand_a, operand_b, result_out);
      total++;
      if (out_valid !== 1'b1 || {carry_flag, zero_flag, overflow_flag, negative_flag, result_out} !== exp) begin
        bad++; $display("FAIL b2b_%0d got=%b/%h want=1/%h", i, out_valid, {carry_flag, zero_flag, overflow_flag, negative_flag, result_out}, exp);
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b want=0", out_valid); end
  endtask

  task automatic test_random();
    logic [4:0] ops [20] = '{5'h01, 5'h02, 5'h03, 5'h0B, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                             5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h00, 5'h0C};
    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [4:0] op;
    logic [31:0] a, b;
    logic [35:0] got, exp;
    int lat, irl;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 19)];
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
      exp = ref_model(op, a, b);
      run_op(op, a, b, lat, irl, got);
      total++;
      if (got !== exp || lat !== ref_lat(op, a, b)) begin
        bad++; $display("FAIL rand_%0d op=%h a=%h b=%h got=%h lat=%0d want=%h lat=%0d", i, op, a, b, got, lat, exp, ref_lat(op, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift_cmp();
    test_mul();
    test_div();
    test_halt();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
